regbus_arbiter: RTL and testbench

- Shares the single internal register bus between two requesters: the SPI register-access front end (master 0) and the Maple protocol sequencer (master 1).
- The register bus consists of the one-hot chip selects, the write strobe, write data and the shared read data.
- Accesses are serialised through a small state machine with round-robin arbitration.
- The block drives the chip selects, write strobe and write data itself, so the register bank never sees two masters at once.

---
 rtl/regbus_arbiter_if.sv | 44 ++++
 rtl/regbus_arbiter.sv | 112 +++++++++++
 tb/tb_regbus_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regbus_arbiter_if.sv
// rtl/regbus_arbiter_if.sv - requester handshakes and register-bank bus shared through regbus_arbiter
interface regbus_arbiter_if #(
    parameter int num_regs = 128
) ();
    logic                m0_req;
    logic                m0_we;
    logic [6:0]          m0_regnum;
    logic [7:0]          m0_wdata;
    logic                m0_ack;
    logic [7:0]          m0_rdata;
    logic                m0_err;

    logic                m1_req;
    logic                m1_we;
    logic [6:0]          m1_regnum;
    logic [7:0]          m1_wdata;
    logic                m1_ack;
    logic [7:0]          m1_rdata;
    logic                m1_err;

    logic [num_regs-1:0] cs;
    logic                we;
    logic [7:0]          regdata_write;
    logic [7:0]          regdata_read;

    // master: the arbiter's view (answers requesters, drives the register bank)
    modport master (
        input  m0_req, m0_we, m0_regnum, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_regnum, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output cs, we, regdata_write,
        input  regdata_read
    );

    modport slave (
        output m0_req, m0_we, m0_regnum, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_regnum, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  cs, we, regdata_write,
        output regdata_read
    );
endinterface

// File: rtl/regbus_arbiter.sv
// rtl/regbus_arbiter.sv - round-robin two-master arbiter for the internal register bus
module regbus_arbiter #(
    parameter int         num_regs  = 128,
    parameter logic [7:0] oor_rdata = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    regbus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_next;

    logic       last_grant;
    logic       grant;
    logic       we_l;
    logic       in_range_l;

    logic       grant_take;
    logic       grant_sel;
    logic       sel_we;
    logic [6:0] sel_regnum;
    logic [7:0] sel_wdata;
    logic       sel_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // When both request, the master that did not win last time gets the bus.
    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        grant_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req && (!bus.m1_req || last_grant)) begin
                    grant_take = 1'b1;
                    grant_sel  = 1'b0;
                    state_next = ACCESS;
                end else if (bus.m1_req) begin
                    grant_take = 1'b1;
                    grant_sel  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_we       = grant_sel ? bus.m1_we     : bus.m0_we;
        sel_regnum   = grant_sel ? bus.m1_regnum : bus.m0_regnum;
        sel_wdata    = grant_sel ? bus.m1_wdata  : bus.m0_wdata;
        sel_in_range = (32'(sel_regnum) < num_regs);
    end

    // Bus outputs are loaded on the grant edge so they are live for exactly the ACCESS cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant        <= 1'b1;
            grant             <= 1'b0;
            we_l              <= 1'b0;
            in_range_l        <= 1'b0;
            bus.cs            <= '0;
            bus.we            <= 1'b0;
            bus.regdata_write <= 8'h00;
            bus.m0_ack        <= 1'b0;
            bus.m0_err        <= 1'b0;
            bus.m0_rdata      <= 8'h00;
            bus.m1_ack        <= 1'b0;
            bus.m1_err        <= 1'b0;
            bus.m1_rdata      <= 8'h00;
        end else begin
            bus.cs            <= '0;
            bus.we            <= 1'b0;
            bus.regdata_write <= 8'h00;
            bus.m0_ack        <= 1'b0;
            bus.m0_err        <= 1'b0;
            bus.m1_ack        <= 1'b0;
            bus.m1_err        <= 1'b0;

            if (grant_take) begin
                grant      <= grant_sel;
                last_grant <= grant_sel;
                we_l       <= sel_we;
                in_range_l <= sel_in_range;
                if (sel_in_range)
                    bus.cs <= num_regs'(1) << sel_regnum;
                bus.we            <= sel_we && sel_in_range;
                bus.regdata_write <= sel_we ? sel_wdata : 8'h00;
            end

            if (state == ACCESS) begin
                if (!grant) begin
                    bus.m0_ack <= 1'b1;
                    bus.m0_err <= !in_range_l;
                    if (!we_l)
                        bus.m0_rdata <= in_range_l ? bus.regdata_read : oor_rdata;
                end else begin
                    bus.m1_ack <= 1'b1;
                    bus.m1_err <= !in_range_l;
                    if (!we_l)
                        bus.m1_rdata <= in_range_l ? bus.regdata_read : oor_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_regbus_arbiter.sv
// tb/tb_regbus_arbiter.sv - directed bench for regbus_arbiter at num_regs 128 and 16
module tb_regbus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regbus_arbiter_if #(.num_regs(128)) ifa ();
    regbus_arbiter_if #(.num_regs(16))  ifb ();

    regbus_arbiter #(.num_regs(128), .oor_rdata(8'hFF)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    regbus_arbiter #(.num_regs(16),  .oor_rdata(8'hFF)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   bank_a [128];
    logic [7:0]   bank_b [16];
    logic [127:0] one = 128'd1;
    logic [127:0] exp_cs;

    always_comb begin
        ifa.regdata_read = 8'h00;
        for (int i = 0; i < 128; i++)
            if (ifa.cs[i]) ifa.regdata_read = bank_a[i];
    end

    always_comb begin
        ifb.regdata_read = 8'h00;
        for (int i = 0; i < 16; i++)
            if (ifb.cs[i]) ifb.regdata_read = bank_b[i];
    end

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) bank_a[i] = 8'(i);
        for (int i = 0; i < 16; i++)  bank_b[i] = 8'(i);
        bank_a[5]   = 8'hA5;
        bank_a[127] = 8'h7E;
        bank_b[15]  = 8'h5A;

        ifa.m0_req = 0; ifa.m0_we = 0; ifa.m0_regnum = 0; ifa.m0_wdata = 0;
        ifa.m1_req = 0; ifa.m1_we = 0; ifa.m1_regnum = 0; ifa.m1_wdata = 0;
        ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_regnum = 0; ifb.m0_wdata = 0;
        ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_regnum = 0; ifb.m1_wdata = 0;

        // reset values
        #12;
        chk("rst_cs", ifa.cs, 0);
        chk("rst_we", ifa.we, 0);
        chk("rst_wdata", ifa.regdata_write, 0);
        chk("rst_acks", {ifa.m0_ack, ifa.m1_ack, ifa.m0_err, ifa.m1_err}, 0);
        chk("rst_rdata", {ifa.m0_rdata, ifa.m1_rdata}, 0);
        rst = 1'b1;
        tick();

        // single read: m0 reads reg 5
        ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_regnum = 7'd5;
        tick();
        chk("rd_cs", ifa.cs, one << 5);
        chk("rd_we", ifa.we, 0);
        chk("rd_ack_early", ifa.m0_ack, 0);
        ifa.m0_req = 0; ifa.m0_regnum = 7'd9;
        tick();
        chk("rd_cs_off", ifa.cs, 0);
        chk("rd_ack", ifa.m0_ack, 1);
        chk("rd_rdata", ifa.m0_rdata, 8'hA5);
        chk("rd_err", ifa.m0_err, 0);
        tick();
        chk("rd_ack_off", ifa.m0_ack, 0);
        chk("rd_rdata_hold", ifa.m0_rdata, 8'hA5);

        // single write: m1 writes 3C to reg 127
        ifa.m1_req = 1; ifa.m1_we = 1; ifa.m1_regnum = 7'd127; ifa.m1_wdata = 8'h3C;
        tick();
        chk("wr_cs", ifa.cs, one << 127);
        chk("wr_we", ifa.we, 1);
        chk("wr_data", ifa.regdata_write, 8'h3C);
        ifa.m1_req = 0;
        tick();
        chk("wr_we_off", ifa.we, 0);
        chk("wr_ack", ifa.m1_ack, 1);
        chk("wr_err", ifa.m1_err, 0);
        chk("wr_rdata", ifa.m1_rdata, 8'h00);
        tick();

        // contention from reset: grants 0,1,0,1 with acks 3 cycles apart
        rst = 1'b0;
        #2;
        rst = 1'b1;
        ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_regnum = 7'd5;
        ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_regnum = 7'd127;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_cs = (k % 2 == 0) ? (one << 5) : (one << 127);
            chk($sformatf("cont_cs%0d", k), ifa.cs, exp_cs);
            tick();
            chk($sformatf("cont_acks%0d", k), {ifa.m0_ack, ifa.m1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 0) chk($sformatf("cont_rd%0d", k), ifa.m0_rdata, 8'hA5);
            else            chk($sformatf("cont_rd%0d", k), ifa.m1_rdata, 8'h7E);
            if (k == 3) begin
                ifa.m0_req = 0;
                ifa.m1_req = 0;
            end
            tick();
            chk($sformatf("cont_gap%0d", k), {ifa.cs, ifa.m0_ack, ifa.m1_ack}, 0);
        end
        tick();
        chk("cont_quiet", {ifa.cs, ifa.m0_ack, ifa.m1_ack}, 0);

        // withdraw before grant, then abort attempt during ACCESS
        ifa.m1_req = 1; ifa.m1_we = 1; ifa.m1_regnum = 7'd3; ifa.m1_wdata = 8'h11;
        #2;
        ifa.m1_req = 0;
        tick();
        chk("wd_cs", {ifa.cs, ifa.we}, 0);
        tick();
        chk("wd_ack", ifa.m1_ack, 0);
        ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_regnum = 7'd5;
        tick();
        chk("ab_cs", ifa.cs, one << 5);
        ifa.m0_req = 0;
        tick();
        chk("ab_ack", ifa.m0_ack, 1);
        tick();

        // async reset during ACCESS
        ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_regnum = 7'd5;
        tick();
        chk("ar_cs_pre", ifa.cs, one << 5);
        ifa.m1_req = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cs", ifa.cs, 0);
        chk("ar_we", ifa.we, 0);
        chk("ar_rdata", ifa.m1_rdata, 8'h00);
        tick();
        chk("ar_ack", ifa.m1_ack, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("ar_ack_after", ifa.m1_ack, 0);
        ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_regnum = 7'd5;
        tick();
        chk("ar_re_cs", ifa.cs, one << 5);
        ifa.m1_req = 0;
        tick();
        chk("ar_re_ack", ifa.m1_ack, 1);
        chk("ar_re_rdata", ifa.m1_rdata, 8'hA5);
        tick();

        // out of range with num_regs=16
        ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_regnum = 7'd20;
        tick();
        chk("oor_rd_bus", {ifb.cs, ifb.we}, 0);
        ifb.m0_req = 0;
        tick();
        chk("oor_rd_ack", ifb.m0_ack, 1);
        chk("oor_rd_err", ifb.m0_err, 1);
        chk("oor_rd_rdata", ifb.m0_rdata, 8'hFF);
        tick();
        chk("oor_err_off", {ifb.m0_ack, ifb.m0_err}, 0);
        ifb.m0_req = 1; ifb.m0_we = 1; ifb.m0_regnum = 7'd20; ifb.m0_wdata = 8'h55;
        tick();
        chk("oor_wr_bus", {ifb.cs, ifb.we}, 0);
        ifb.m0_req = 0;
        tick();
        chk("oor_wr_ack", {ifb.m0_ack, ifb.m0_err}, 2'b11);
        chk("oor_wr_we", ifb.we, 0);
        tick();
        ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_regnum = 7'd15;
        tick();
        chk("top_cs", ifb.cs, one << 15);
        ifb.m0_req = 0;
        tick();
        chk("top_ack", {ifb.m0_ack, ifb.m0_err}, 2'b10);
        chk("top_rdata", ifb.m0_rdata, 8'h5A);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
